out_mem_reader: RTL and testbench

// Read-side engine for the output pixel memory. After a start pulse it scans the output-image window
// (addresses OUT_BASE .. OUT_BASE+COUNT-1) of the 24-bit data memory through its address/read port and streams pixels
// out on a valid/ready interface (to the display/UART dump path). It never writes memory (mem_we tied 0).

---
 rtl/out_mem_pkg.sv | 28 ++
 rtl/pix_skid_fifo.sv | 74 +++++++
 rtl/out_mem_reader.sv | 156 +++++++++++++++
 tb/tb_out_mem_reader.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/out_mem_pkg.sv
// Shared types and constants for the output-memory read engine.
//   WIDTH       pixel / memory word width, also the address width
//   OUT_BASE    first address of the output image window
//   COUNT       pixels per frame (300x300)
//   pixel_t     one memory word / pixel
//   rd_state_t  reader FSM states
//   pix_entry_t buffered pixel plus its end-of-frame tag
package out_mem_pkg;

    localparam int unsigned WIDTH    = 24;
    localparam int unsigned OUT_BASE = 90302;
    localparam int unsigned COUNT    = 90000;

    typedef logic [WIDTH-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } rd_state_t;

    typedef struct packed {
        pixel_t data;
        logic   last;
    } pix_entry_t;

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry pixel buffer between the memory return path and the pixel sink.
//   clk, rst_n  clock, asynchronous active-low reset
//   flush       synchronous clear of pointers and occupancy
//   push        write push_entry at the tail
//   pop         drop the head entry
//   head        entry at the head (meaningful when !empty)
//   full/empty  occupancy flags
//   count       number of entries held (0..2)
module pix_skid_fifo
    import out_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  pix_entry_t push_entry,
    input  logic       pop,
    output pix_entry_t head,
    output logic       full,
    output logic       empty,
    output logic [1:0] count
);

    pix_entry_t entry_q [2];
    pix_entry_t entry_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;

    always_comb begin
        // NOTE: every _d signal gets its default first, so no path through this block can infer a latch.
        entry_d  = entry_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                entry_d[wr_ptr_q] = push_entry;
                wr_ptr_d          = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            // Push and pop together on a full buffer leaves the count unchanged.
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // NOTE: non-blocking (<=) in clocked blocks so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset too; it is only two words and it keeps the head free of X after reset.
            entry_q  <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            entry_q  <= entry_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = entry_q[rd_ptr_q];
    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign count = count_q;

endmodule

// File: rtl/out_mem_reader.sv
// Read-side engine for the output pixel memory. A start pulse scans the window
// FRAME_BASE .. FRAME_BASE+FRAME_COUNT-1 through a 1-cycle-latency read port and
// streams the words out on a valid/ready pixel interface. Never writes memory.
//   clk, rst_n   clock, asynchronous active-low reset
//   start        1-cycle pulse, honoured only in IDLE or DONE
//   abort        level, returns to IDLE on the next edge and discards everything
//   mem_a        read address (registered by the memory)
//   mem_we       constant 0
//   mem_rd       read data, valid the cycle after the address was issued
//   pix_data/pix_valid/pix_ready/pix_last  pixel stream, last marks index COUNT-1
//   busy         RUN or DRAIN
//   done         1-cycle pulse after the last pixel is accepted
module out_mem_reader
    import out_mem_pkg::*;
#(
    parameter int unsigned FRAME_BASE  = OUT_BASE,
    parameter int unsigned FRAME_COUNT = COUNT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] mem_a,
    output logic             mem_we,
    input  logic [WIDTH-1:0] mem_rd,
    output logic [WIDTH-1:0] pix_data,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             pix_last,
    output logic             busy,
    output logic             done
);

    if (FRAME_COUNT == 0 || FRAME_COUNT >= 2**WIDTH || FRAME_BASE + FRAME_COUNT > 2**WIDTH) begin : g_bad_window
        $error("out_mem_reader: frame window does not fit in WIDTH-bit addresses/counters");
    end

    localparam pixel_t BASE_A   = pixel_t'(FRAME_BASE);
    localparam pixel_t LAST_IDX = pixel_t'(FRAME_COUNT - 1);
    localparam pixel_t END_CNT  = pixel_t'(FRAME_COUNT);

    rd_state_t  state_q, state_d;
    pixel_t     mem_a_q, mem_a_d;
    pixel_t     issue_cnt_q, issue_cnt_d;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_last_q, rd_last_d;
    logic       done_q, done_d;

    logic       issue, push, pop;
    logic [2:0] occ_after;
    pix_entry_t push_entry, head;
    logic       fifo_full, fifo_empty;
    logic [1:0] fifo_count;

    assign pop        = pix_valid && pix_ready;
    assign push       = rd_pend_q && !abort;
    assign push_entry = '{data: mem_rd, last: rd_last_q};

    // Occupancy the buffer will hold after this edge counting the read already in
    // flight. Crediting this cycle's pop is what allows 1 pixel/cycle; an issue
    // is still only made when the returning word is guaranteed a free slot.
    assign occ_after = {2'b00, rd_pend_q} + {1'b0, fifo_count} - {2'b00, pop};
    assign issue     = (state_q == RUN) && (issue_cnt_q != END_CNT) && (occ_after < 3'd2);

    always_comb begin
        state_d     = state_q;
        mem_a_d     = mem_a_q;
        issue_cnt_d = issue_cnt_q;
        rd_pend_d   = issue;
        rd_last_d   = issue && (issue_cnt_q == LAST_IDX);
        done_d      = 1'b0;

        if (issue) begin
            issue_cnt_d = issue_cnt_q + pixel_t'(1);
            // The final issue leaves mem_a parked on the last window address.
            if (issue_cnt_q != LAST_IDX) begin
                mem_a_d = mem_a_q + pixel_t'(1);
            end
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RUN;
                    mem_a_d     = BASE_A;
                    issue_cnt_d = '0;
                end
            end
            RUN: begin
                if (issue_cnt_q == END_CNT) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head.last) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort beats everything, including a simultaneous start.
        if (abort) begin
            state_d     = IDLE;
            mem_a_d     = BASE_A;
            issue_cnt_d = '0;
            rd_pend_d   = 1'b0;
            rd_last_d   = 1'b0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_a_q     <= BASE_A;
            issue_cnt_q <= '0;
            rd_pend_q   <= 1'b0;
            rd_last_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_a_q     <= mem_a_d;
            issue_cnt_q <= issue_cnt_d;
            rd_pend_q   <= rd_pend_d;
            rd_last_q   <= rd_last_d;
            done_q      <= done_d;
        end
    end

    pix_skid_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (abort),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // The issue rule makes a push into a full buffer without a matching pop impossible.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full && !pop));

    assign mem_a     = mem_a_q;
    assign mem_we    = 1'b0;
    assign pix_data  = head.data;
    assign pix_last  = head.last;
    assign pix_valid = !fifo_empty;
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = done_q;

endmodule

// File: tb/tb_out_mem_reader.sv
// Directed bench for out_mem_reader with a shortened frame so every scenario
// fits a small cycle budget. Memory model: mem[k] = k ^ 24'hA5A5A5, 1-cycle read.
module tb_out_mem_reader;

    localparam int          N    = 2000;
    localparam int          BASE = 90302;
    localparam logic [23:0] KEY  = 24'hA5A5A5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [23:0] mem_a;
    logic        mem_we;
    logic [23:0] mem_rd = '0;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_last;
    logic        busy;
    logic        done;

    int n_pass   = 0;
    int n_checks = 0;

    out_mem_reader #(
        .FRAME_BASE  (BASE),
        .FRAME_COUNT (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .mem_a     (mem_a),
        .mem_we    (mem_we),
        .mem_rd    (mem_rd),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_last  (pix_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Behavioural memory: address registered, data returned the next cycle.
    always @(posedge clk) mem_rd <= mem_a ^ KEY;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [23:0] exp_pix(input int i);
        return 24'(BASE + i) ^ KEY;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Starts a frame at the current negedge and streams it. hold: cycles with
    // ready forced low; pct: ready probability afterwards; pulse_at: cycle of an
    // extra start pulse (-1 none); stop_at: return once that many pixels are
    // accepted (-1 = run to done). Cycle k is the negedge after the k-th edge
    // following the start edge.
    task automatic run_frame(input string tag, input int hold, input int pct,
                             input int pulse_at, input int stop_at);
        int   n_acc = 0, errs = 0, hold_errs = 0, done_cnt = 0, last_cnt = 0;
        int   done_k = -1, first_k = -1, max_out = 0, we_errs = 0, outst;
        logic busy_at_done = 1'b1;
        start     = 1'b1;
        pix_ready = 1'b0;
        for (int k = 0; k < 20 * N + 500; k++) begin
            @(negedge clk);
            start = (k == pulse_at);
            if (k == 0) begin
                check({tag, "_start_addr"}, mem_a, BASE);
                check({tag, "_start_empty"}, pix_valid, 0);
                check({tag, "_start_busy"}, busy, 1);
            end
            if (pulse_at >= 0 && k == pulse_at + 1)
                check({tag, "_start_ignored"}, (mem_a != 24'(BASE)) && busy, 1);
            if (mem_we) we_errs++;
            if (pix_valid && first_k < 0) first_k = k;
            if (done) begin
                done_cnt++;
                if (done_k < 0) begin
                    done_k       = k;
                    busy_at_done = busy;
                end
            end
            if (n_acc == stop_at) begin
                pix_ready = 1'b0;
                break;
            end
            if (done_k >= 0 && k >= done_k + 3) break;
            if (k < hold) begin
                pix_ready = 1'b0;
                if (k >= 2 && (!pix_valid || pix_data !== exp_pix(0))) hold_errs++;
            end else begin
                pix_ready = ($urandom_range(99) < pct);
            end
            if (hold > 0 && k == hold - 1) begin
                check({tag, "_hold_valid"}, pix_valid, 1);
                check({tag, "_hold_data"}, pix_data, exp_pix(0));
                check({tag, "_hold_issues"}, mem_a, BASE + 2);
            end
            if (mem_a != 24'(BASE + N - 1)) begin
                outst = (int'(mem_a) - BASE) - n_acc;
                if (outst > max_out) max_out = outst;
            end
            if (pix_valid) begin
                if (pix_data !== exp_pix(n_acc) || pix_last !== (n_acc == N - 1)) errs++;
                if (pix_ready) begin
                    if (pix_last) last_cnt++;
                    n_acc++;
                end
            end
        end
        check({tag, "_data_errs"}, errs, 0);
        if (stop_at >= 0) begin
            check({tag, "_stop_reached"}, n_acc, stop_at);
        end else begin
            check({tag, "_pixels"}, n_acc, N);
            check({tag, "_last_once"}, last_cnt, 1);
            check({tag, "_done_once"}, done_cnt, 1);
            check({tag, "_idle_at_done"}, busy_at_done, 0);
            check({tag, "_max_outstanding_le2"}, max_out <= 2, 1);
            check({tag, "_mem_we"}, we_errs, 0);
            check({tag, "_addr_parked"}, mem_a, BASE + N - 1);
            if (hold > 0) check({tag, "_hold_stable"}, hold_errs, 0);
            if (hold == 0 && pct >= 100) begin
                check({tag, "_first_valid_cycle"}, first_k, 2);
                check({tag, "_start_to_done"}, done_k, N + 2);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        pix_ready = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_mem_a", mem_a, BASE);
        check("rst_valid", pix_valid, 0);
        check("rst_last", pix_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_we", mem_we, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_start", busy, 0);

        run_frame("full", 0, 100, -1, -1);
        run_frame("bp", 100, 30, 150, -1);

        // Abort mid-frame with a read in flight.
        run_frame("abort", 0, 100, -1, 1234);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", pix_valid, 0);
        check("abort_addr", mem_a, BASE);
        repeat (3) @(negedge clk);
        check("abort_inflight_dropped", pix_valid, 0);
        check("abort_stays_idle", busy, 0);
        run_frame("after_abort", 0, 100, -1, -1);

        // Asynchronous reset mid-frame.
        run_frame("reset", 0, 100, -1, 500);
        rst_n = 1'b0;
        #1;
        check("midrst_mem_a", mem_a, BASE);
        check("midrst_valid", pix_valid, 0);
        check("midrst_last", pix_last, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame("after_reset", 0, 60, -1, -1);

        // start and abort together from DONE: abort wins, reader lands in IDLE.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", busy, 0);
        check("start_abort_addr", mem_a, BASE);
        repeat (3) @(negedge clk);
        check("start_abort_no_run", busy, 0);
        check("start_abort_no_valid", pix_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
